// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial test link (transmitter and receiver).
package serial_link_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_PARITY,
    TX_GAP
  } tx_state_t;

  // Bit period shared by both ends of the link unless a side overrides it.
  localparam int DEFAULT_CLKS_PER_BIT = 1;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int PARITY_MAX_W = 32;

  // Even parity: the appended bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/bit_period_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running and pulses o_Tick
// on the last clock of each period. Holds at 0 whenever i_Run is low, so every
// run starts with a full period. Shared by the serial transmitter and receiver.
module bit_period_timer
  import serial_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Run,
  output logic o_Tick
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign o_Tick = i_Run && (count == CNT_LAST);

  // Period counter: restart after each tick or whenever the timer is stopped.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count <= '0;
    end else if (!i_Run || o_Tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter with valid/ready intake, per-bit strobe,
// frame marker and end-of-frame pulse. One word in flight, no buffering.
// Optional feature: define SERIAL_WORD_TX_PARITY_EN to append an even-parity
// bit after the data bits (o_Done then moves to the parity bit's strobe).
module serial_word_tx
  import serial_link_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int GAP_CYCLES   = 2,
  parameter int LSB_FIRST    = 0
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic [WIDTH-1:0] i_Data,
  input  logic             i_Valid,
  output logic             o_Ready,
  output logic             o_SerialData,
  output logic             o_BitStrobe,
  output logic             o_Frame,
  output logic             o_Done
);

  localparam int               BIT_W    = $clog2(WIDTH) + 1;
  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t        state, state_next;
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [WIDTH-1:0] shreg;
  logic             tick;
  logic             run;
  logic             handshake;
  logic             last_data_bit;
  logic             cur_bit;
`ifdef SERIAL_WORD_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign o_Ready       = (state == TX_IDLE);
  assign handshake     = i_Valid && o_Ready;
  assign run           = (state == TX_SHIFT) || (state == TX_PARITY);
  assign o_Frame       = run;
  assign o_BitStrobe   = tick;
  assign cur_bit       = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];
  assign last_data_bit = (state == TX_SHIFT) && tick && (bit_cnt == BIT_LAST);

`ifdef SERIAL_WORD_TX_PARITY_EN
  assign o_SerialData = (state == TX_PARITY) ? parity_bit :
                        (state == TX_SHIFT)  ? cur_bit    : 1'b0;
  assign o_Done       = (state == TX_PARITY) && tick;
`else
  assign o_SerialData = (state == TX_SHIFT) ? cur_bit : 1'b0;
  assign o_Done       = last_data_bit;
`endif

  bit_period_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .i_Clock  (i_Clock),
    .i_Reset_n(i_Reset_n),
    .i_Run    (run),
    .o_Tick   (tick)
  );

  // State register.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= TX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: frame bits, optional parity bit, then optional idle gap.
  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE: begin
        if (handshake) state_next = TX_SHIFT;
      end
      TX_SHIFT: begin
        if (last_data_bit) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
          state_next = TX_PARITY;
`else
          if (GAP_CYCLES == 0) state_next = TX_IDLE;
          else                 state_next = TX_GAP;
`endif
        end
      end
      TX_PARITY: begin
`ifdef SERIAL_WORD_TX_PARITY_EN
        if (tick) begin
          if (GAP_CYCLES == 0) state_next = TX_IDLE;
          else                 state_next = TX_GAP;
        end
`else
        state_next = TX_IDLE;
`endif
      end
      TX_GAP: begin
        if (gap_cnt == GAP_LAST) state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // Shift register and bit counter: load on handshake, advance on each bit strobe.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (handshake) begin
      shreg   <= i_Data;
      bit_cnt <= '0;
    end else if ((state == TX_SHIFT) && tick) begin
      shreg   <= (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
      bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

`ifdef SERIAL_WORD_TX_PARITY_EN
  // Parity is taken from the word as accepted, so later i_Data changes cannot leak in.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      parity_bit <= 1'b0;
    end else if (handshake) begin
      parity_bit <= even_parity(PARITY_MAX_W'(i_Data));
    end
  end
`endif

  // Gap counter: runs only in the gap state, cleared everywhere else.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      gap_cnt <= '0;
    end else if (state == TX_GAP) begin
      gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed, table-driven bench for serial_word_tx. Three instances cover the
// default build, LSB-first with 3 clocks per bit, and zero gap. Output vectors
// are packed as {ready, serial, strobe, frame, done}.
module tb_serial_word_tx;

`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int PAR_BITS = 1;
  localparam logic [9:0] EXP_B2B = 10'b10100_01010;
`else
  localparam int PAR_BITS = 0;
  localparam logic [9:0] EXP_B2B = 10'b00_1010_0101;
`endif
  localparam int NB = 4 + PAR_BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0] data_a = '0, data_b = '0, data_c = '0;
  logic valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic ready_a, ser_a, stb_a, frm_a, done_a;
  logic ready_b, ser_b, stb_b, frm_b, done_b;
  logic ready_c, ser_c, stb_c, frm_c, done_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_word_tx dut_a (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Data(data_a), .i_Valid(valid_a),
    .o_Ready(ready_a), .o_SerialData(ser_a), .o_BitStrobe(stb_a),
    .o_Frame(frm_a), .o_Done(done_a)
  );

  serial_word_tx #(.WIDTH(4), .CLKS_PER_BIT(3), .GAP_CYCLES(2), .LSB_FIRST(1)) dut_b (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Data(data_b), .i_Valid(valid_b),
    .o_Ready(ready_b), .o_SerialData(ser_b), .o_BitStrobe(stb_b),
    .o_Frame(frm_b), .o_Done(done_b)
  );

  serial_word_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .GAP_CYCLES(0), .LSB_FIRST(0)) dut_c (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Data(data_c), .i_Valid(valid_c),
    .o_Ready(ready_c), .o_SerialData(ser_c), .o_BitStrobe(stb_c),
    .o_Frame(frm_c), .o_Done(done_c)
  );

  typedef struct {
    int         sel;
    logic [3:0] word;
    logic [3:0] seq;     // transmission order, bit 3 goes out first
    logic       par;
    bit         disturb;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [4:0] outs(input int sel);
    case (sel)
      0:       return {ready_a, ser_a, stb_a, frm_a, done_a};
      1:       return {ready_b, ser_b, stb_b, frm_b, done_b};
      default: return {ready_c, ser_c, stb_c, frm_c, done_c};
    endcase
  endfunction

  function automatic int cpb_of(input int sel);
    return (sel == 1) ? 3 : 1;
  endfunction

  function automatic int gap_of(input int sel);
    return (sel == 2) ? 0 : 2;
  endfunction

  task automatic set_in(input int sel, input logic [3:0] d, input logic v);
    case (sel)
      0:       begin data_a = d; valid_a = v; end
      1:       begin data_b = d; valid_b = v; end
      default: begin data_c = d; valid_c = v; end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One complete frame: idle check, handshake, every bit cycle, every gap cycle.
  task automatic run_frame(input int sel, input logic [3:0] word, input logic [3:0] seq,
                           input logic par, input bit disturb, input string name);
    int   cpb, gap;
    logic eb, stb, dn;
    cpb = cpb_of(sel);
    gap = gap_of(sel);
    @(negedge clk);
    chk({name, "_idle"}, outs(sel), 5'b10000);
    set_in(sel, word, 1'b1);
    @(posedge clk);
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (b == 0 && c == 0) set_in(sel, word, 1'b0);
        if (disturb && b == 1 && c == 0) set_in(sel, ~word, 1'b1);
        if (disturb && b == 2 && c == 0) set_in(sel, ~word, 1'b0);
        eb  = (b < 4) ? seq[3-b] : par;
        stb = (c == cpb - 1);
        dn  = stb && (b == NB - 1);
        chk($sformatf("%s_bit%0d_clk%0d", name, b, c), outs(sel), {1'b0, eb, stb, 1'b1, dn});
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if (disturb && g == 0) set_in(sel, word, 1'b1);
      if (disturb && g == gap - 1) set_in(sel, word, 1'b0);
      chk($sformatf("%s_gap%0d", name, g), outs(sel), 5'b00000);
    end
  endtask

  initial begin
    logic [4:0] o;
    logic [9:0] got;
    int         nbits_got, dcnt, idle;

    vecs[0] = '{0, 4'b1011, 4'b1011, 1'b1, 1'b0};
    vecs[1] = '{0, 4'b0111, 4'b0111, 1'b1, 1'b0};
    vecs[2] = '{0, 4'b0110, 4'b0110, 1'b0, 1'b0};
    vecs[3] = '{0, 4'b0000, 4'b0000, 1'b0, 1'b0};
    vecs[4] = '{0, 4'b1111, 4'b1111, 1'b0, 1'b0};
    vecs[5] = '{1, 4'b0001, 4'b1000, 1'b1, 1'b0};
    vecs[6] = '{1, 4'b1100, 4'b0011, 1'b0, 1'b0};
    vecs[7] = '{1, 4'b1011, 4'b1101, 1'b1, 1'b0};
    vecs[8] = '{0, 4'b1001, 4'b1001, 1'b0, 1'b1};

    // Reset state
    @(negedge clk);
    for (int s = 0; s < 3; s++) chk($sformatf("in_reset_%0d", s), outs(s) & 5'b01111, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) chk($sformatf("after_reset_%0d", s), outs(s), 5'b10000);

    // Table: default, LSB-first/3 clocks per bit, and busy-time disturbance last
    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i].sel, vecs[i].word, vecs[i].seq, vecs[i].par, vecs[i].disturb,
                $sformatf("vec%0d", i));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("no_extra_frame_%0d", k), outs(0), 5'b10000);
    end

    // Reset in the middle of bit index 2
    @(negedge clk);
    set_in(0, 4'b1101, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 4'b1101, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_bit2", outs(0), 5'b00110);
    #1 rst_n = 1'b0;
    #1 chk("abort_outputs", outs(0) & 5'b01111, 5'b00000);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("abort_hold_%0d", k), outs(0) & 5'b01111, 5'b00000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release", outs(0), 5'b10000);
    run_frame(0, 4'b0110, 4'b0110, 1'b0, 1'b0, "post_abort");

    // Back-to-back with zero gap and i_Valid held high
    got = '0;
    nbits_got = 0;
    dcnt = 0;
    idle = 0;
    @(negedge clk);
    set_in(2, 4'hA, 1'b1);
    @(posedge clk);
    for (int cyc = 1; cyc <= 2 * NB + 1; cyc++) begin
      @(negedge clk);
      o = outs(2);
      if (o[1]) begin
        got = {got[8:0], o[3]};
        nbits_got++;
      end
      if (o[0]) dcnt++;
      if (o[4]) begin
        idle++;
        set_in(2, 4'h5, 1'b1);
      end
    end
    set_in(2, 4'h5, 1'b0);
    chk("b2b_bits", got, EXP_B2B);
    chk("b2b_framed_cycles", nbits_got, 2 * NB);
    chk("b2b_done_pulses", dcnt, 2);
    chk("b2b_idle_cycles", idle, 1);
    @(negedge clk);
    chk("b2b_end_idle", outs(2), 5'b10000);
    @(negedge clk);
    chk("b2b_no_third", outs(2), 5'b10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
